// File: rtl/bcd_score_counter.sv
// Multi-digit BCD score counter with high-score latch and 7-segment drive.
// Sits between the game logic incr pulse and the board HEX displays.
module bcd_score_counter #(
  parameter int NUM_DIGITS    = 3,
  parameter bit WRAP          = 1'b0,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic                    incr,
  input  logic                    par_load,
  input  logic [4*NUM_DIGITS-1:0] d,
  output logic [4*NUM_DIGITS-1:0] score,
  output logic [4*NUM_DIGITS-1:0] high_score,
  output logic                    new_high,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int W = 4 * NUM_DIGITS;

  logic [W-1:0] inc_val;
  logic [W-1:0] load_val;
  logic [W-1:0] next_score;
  logic         next_ov;
  logic         carry;
  logic         bump;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0011000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // carry out of the top digit means the score is all 9s
  always_comb begin
    inc_val  = score;
    load_val = d;
    carry    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score[4*i +: 4] == 4'd9) begin
          inc_val[4*i +: 4] = 4'd0;
        end else begin
          inc_val[4*i +: 4] = score[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (d[4*i +: 4] > 4'd9)
        load_val[4*i +: 4] = 4'd0;
    end
  end

  always_comb begin
    next_score = score;
    next_ov    = overflow;
    if (clear) begin
      next_score = '0;
      next_ov    = 1'b0;
    end else if (par_load) begin
      next_score = load_val;
      next_ov    = 1'b0;
    end else if (enable && incr) begin
      if (carry) next_ov = 1'b1;
      next_score = (carry && !WRAP) ? score : inc_val;
    end
    bump = next_score > high_score;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      score      <= '0;
      high_score <= '0;
      new_high   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      score    <= next_score;
      overflow <= next_ov;
      new_high <= bump;
      if (bump) high_score <= next_score;
    end
  end

  // walk from the top digit so "lead" tracks all-higher-digits-zero
  always_comb begin
    logic lead;
    logic [3:0] nib;
    hex_out = '1;
    lead    = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      nib  = score[4*i +: 4];
      lead = lead && (nib == 4'd0);
      if (BLANK_LEADING && i != 0 && lead)
        hex_out[7*i +: 7] = 7'b1111111;
      else
        hex_out[7*i +: 7] = seg7(nib);
    end
  end

endmodule

// File: tb/tb_bcd_score_counter.sv
// Directed table-driven bench for bcd_score_counter.
// Checks a saturating/blanking instance and a wrapping/unblanked one.
module tb_bcd_score_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        enable = 1'b0;
  logic        incr = 1'b0;
  logic        par_load = 1'b0;
  logic [11:0] d = '0;

  logic [11:0] s0, h0, s1, h1;
  logic        nh0, ov0, nh1, ov1;
  logic [20:0] hx0, hx1;

  int n_pass = 0;
  int n_tot  = 0;

  always #5 clock = ~clock;

  bcd_score_counter #(.NUM_DIGITS(3), .WRAP(1'b0), .BLANK_LEADING(1'b1)) dut0 (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable),
    .incr(incr), .par_load(par_load), .d(d),
    .score(s0), .high_score(h0), .new_high(nh0), .overflow(ov0),
    .hex_out(hx0)
  );

  bcd_score_counter #(.NUM_DIGITS(3), .WRAP(1'b1), .BLANK_LEADING(1'b0)) dut1 (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable),
    .incr(incr), .par_load(par_load), .d(d),
    .score(s1), .high_score(h1), .new_high(nh1), .overflow(ov1),
    .hex_out(hx1)
  );

  typedef struct {
    logic        rst, clr, en, inc, ld;
    logic [11:0] d;
    logic [11:0] s, h;
    logic        nh, ov;
    logic        chx;
    logic [20:0] hx;
  } vec_t;

  vec_t tv[$];

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] G0 = 7'b1000000;
  localparam logic [6:0] G1 = 7'b1111001;
  localparam logic [6:0] G2 = 7'b0100100;
  localparam logic [6:0] G3 = 7'b0110000;
  localparam logic [6:0] G5 = 7'b0010010;

  function automatic vec_t mk(
    logic rst, logic clr, logic en, logic inc, logic ld, logic [11:0] dv,
    logic [11:0] s, logic [11:0] h, logic nh, logic ov);
    vec_t v;
    v.rst = rst; v.clr = clr; v.en = en; v.inc = inc; v.ld = ld;
    v.d = dv; v.s = s; v.h = h; v.nh = nh; v.ov = ov;
    v.chx = 1'b0; v.hx = '0;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(logic rst, logic clr, logic en, logic inc,
                       logic ld, logic [11:0] dv);
    reset = rst; clear = clr; enable = en; incr = inc;
    par_load = ld; d = dv;
    @(posedge clock);
    #1;
    reset = 0; clear = 0; enable = 0; incr = 0; par_load = 0;
  endtask

  initial begin
    vec_t v;
    logic [11:0] b;
    tv.push_back(mk(1,0,0,0,0,12'h000, 12'h000,12'h000,0,0));
    tv[$].chx = 1; tv[$].hx = {BL, BL, G0};
    for (int i = 1; i <= 12; i++) begin
      b = (i < 10) ? 12'(i) : 12'(16 + i - 10);
      tv.push_back(mk(0,0,1,1,0,12'h000, b,b,1,0));
    end
    tv[$].chx = 1; tv[$].hx = {BL, G1, G2};
    tv.push_back(mk(0,0,0,0,1,12'h099, 12'h099,12'h099,1,0));
    tv.push_back(mk(0,0,1,1,0,12'h000, 12'h100,12'h100,1,0));
    tv[$].chx = 1; tv[$].hx = {G1, G0, G0};
    tv.push_back(mk(0,0,0,0,1,12'h998, 12'h998,12'h998,1,0));
    tv.push_back(mk(0,0,1,1,0,12'h000, 12'h999,12'h999,1,0));
    tv.push_back(mk(0,0,1,1,0,12'h000, 12'h999,12'h999,0,1));
    tv.push_back(mk(0,0,1,1,0,12'h000, 12'h999,12'h999,0,1));
    tv.push_back(mk(0,0,0,0,1,12'h123, 12'h123,12'h999,0,0));
    tv.push_back(mk(0,0,1,1,0,12'h000, 12'h124,12'h999,0,0));
    tv.push_back(mk(0,1,0,0,0,12'h000, 12'h000,12'h999,0,0));
    tv.push_back(mk(0,0,1,1,1,12'h050, 12'h050,12'h999,0,0));
    tv[$].chx = 1; tv[$].hx = {BL, G5, G0};
    tv.push_back(mk(0,1,0,0,1,12'h050, 12'h000,12'h999,0,0));
    tv.push_back(mk(0,0,0,0,1,12'h0A3, 12'h003,12'h999,0,0));
    tv[$].chx = 1; tv[$].hx = {BL, BL, G3};
    for (int i = 4; i <= 7; i++)
      tv.push_back(mk(0,0,1,1,0,12'h000, 12'(i),12'h999,0,0));
    tv.push_back(mk(1,0,1,1,1,12'h555, 12'h000,12'h000,0,0));
    for (int i = 0; i < 5; i++)
      tv.push_back(mk(0,0,0,1,0,12'h000, 12'h000,12'h000,0,0));
    tv.push_back(mk(0,0,1,0,0,12'h000, 12'h000,12'h000,0,0));

    repeat (2) @(posedge clock);
    #1;
    foreach (tv[k]) begin
      v = tv[k];
      drive(v.rst, v.clr, v.en, v.inc, v.ld, v.d);
      chk($sformatf("v%0d score", k), 32'(s0), 32'(v.s));
      chk($sformatf("v%0d high", k), 32'(h0), 32'(v.h));
      chk($sformatf("v%0d new_high", k), 32'(nh0), 32'(v.nh));
      chk($sformatf("v%0d overflow", k), 32'(ov0), 32'(v.ov));
      if (v.chx)
        chk($sformatf("v%0d hex", k), 32'(hx0), 32'(v.hx));
    end

    drive(1,0,0,0,0,12'h000);
    chk("w reset hex unblanked", 32'(hx1), 32'({G0, G0, G0}));
    chk("w reset score", 32'(s1), 32'h0);
    drive(0,0,0,0,1,12'h999);
    chk("w load score", 32'(s1), 32'h999);
    chk("w load new_high", 32'(nh1), 32'h1);
    drive(0,0,1,1,0,12'h000);
    chk("w roll score", 32'(s1), 32'h000);
    chk("w roll overflow", 32'(ov1), 32'h1);
    chk("w roll high", 32'(h1), 32'h999);
    chk("w roll new_high", 32'(nh1), 32'h0);
    chk("w roll hex", 32'(hx1), 32'({G0, G0, G0}));
    chk("s hold score", 32'(s0), 32'h999);
    chk("s hold overflow", 32'(ov0), 32'h1);
    drive(0,0,1,1,0,12'h000);
    chk("w next score", 32'(s1), 32'h001);
    chk("w sticky overflow", 32'(ov1), 32'h1);
    chk("w next high", 32'(h1), 32'h999);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
